// File: rtl/buffer_seq_ctrl.sv
// rtl/buffer_seq_ctrl.sv - tile buffer sequencer: one load phase, then P replay passes of N rows
module buffer_seq_ctrl #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int PASS_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_num_rows,
   input  logic [PASS_W-1:0] i_num_passes,
   input  logic              i_abort,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr_wr,
   output logic              o_rd_valid,
   input  logic              i_rd_ready,
   output logic [ADDR_W-1:0] o_addr_rd,
   output logic              o_rd_last,
   output logic              o_rd_final,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wr_cnt, rd_cnt, n_q;
   logic [PASS_W-1:0] pass_cnt, p_q;
   logic              err_q;
   logic              cfg_ok, wr_last, rd_last, pass_last;

   assign cfg_ok    = (i_num_rows != '0) && (i_num_rows <= DEPTH_C) && (i_num_passes != '0);
   assign wr_last   = (wr_cnt == n_q - 1'b1);
   assign rd_last   = (rd_cnt == n_q - 1'b1);
   assign pass_last = (pass_cnt == p_q - 1'b1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs decode only from state_q, so an async reset forces them all to 0 at once.
   always_comb begin
      state_d    = state_q;
      o_wr_ready = 1'b0;
      o_addr_wr  = '0;
      o_rd_valid = 1'b0;
      o_addr_rd  = '0;
      o_rd_last  = 1'b0;
      o_rd_final = 1'b0;
      o_done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start && cfg_ok) state_d = LOAD;
         end
         LOAD: begin
            o_wr_ready = 1'b1;
            o_addr_wr  = wr_cnt[ADDR_W-1:0];
            if (i_wr_valid && wr_last) state_d = READ;
         end
         READ: begin
            o_rd_valid = 1'b1;
            o_addr_rd  = rd_cnt[ADDR_W-1:0];
            o_rd_last  = rd_last;
            o_rd_final = rd_last && pass_last;
            if (i_rd_ready && rd_last && pass_last) state_d = DONE;
         end
         DONE: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (i_abort) state_d = IDLE;
   end

   assign o_we   = i_wr_valid & o_wr_ready;
   assign o_busy = (state_q == LOAD) || (state_q == READ);
   assign o_err  = err_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         pass_cnt <= '0;
         n_q      <= '0;
         p_q      <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= (state_q == IDLE) && i_start && !cfg_ok && !i_abort;
         if (i_abort) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            pass_cnt <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (i_start && cfg_ok) begin
                     n_q      <= i_num_rows;
                     p_q      <= i_num_passes;
                     wr_cnt   <= '0;
                     rd_cnt   <= '0;
                     pass_cnt <= '0;
                  end
               end
               LOAD: begin
                  if (o_we) wr_cnt <= wr_cnt + 1'b1;
               end
               READ: begin
                  if (i_rd_ready) begin
                     if (rd_last) begin
                        rd_cnt   <= '0;
                        pass_cnt <= pass_cnt + 1'b1;
                     end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_buffer_seq_ctrl.sv
// tb/tb_buffer_seq_ctrl.sv - directed vector bench for buffer_seq_ctrl with a behavioural tile buffer
module tb_buffer_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] num_rows;
   logic [7:0] num_passes;
   logic       abort;
   logic       wr_valid, wr_ready, we;
   logic [3:0] addr_wr, addr_rd;
   logic       rd_valid, rd_ready, rd_last, rd_final;
   logic       busy, done, err;
   logic [7:0] wr_data;
   logic [7:0] mem [16];

   int checks = 0;
   int errors = 0;
   int done_events = 0;
   int err_events = 0;

   always #5 clk = ~clk;

   buffer_seq_ctrl #(.DEPTH(16), .PASS_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_rows(num_rows),
      .i_num_passes(num_passes), .i_abort(abort), .i_wr_valid(wr_valid),
      .o_wr_ready(wr_ready), .o_we(we), .o_addr_wr(addr_wr), .o_rd_valid(rd_valid),
      .i_rd_ready(rd_ready), .o_addr_rd(addr_rd), .o_rd_last(rd_last),
      .o_rd_final(rd_final), .o_busy(busy), .o_done(done), .o_err(err)
   );

   always @(posedge clk) if (we) mem[addr_wr] <= wr_data;

   always @(negedge clk) begin
      if (done) done_events <= done_events + 1;
      if (err)  err_events  <= err_events + 1;
   end

   typedef struct {
      int n; int p; int gap;
      int exp_w; int exp_r; int exp_done; int exp_err; int exp_cyc;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int k);
      return 8'(k * 29 + 7);
   endfunction

   task automatic run_tile(input int n, input int p, input int gap,
                           output int writes, output int reads, output int dones,
                           output int errs, output int done_cyc);
      int  limit, nn;
      bit  legal;
      writes = 0; reads = 0; dones = 0; errs = 0; done_cyc = -1;
      legal  = (n >= 1) && (n <= 16) && (p >= 1);
      limit  = legal ? 3000 : 4;
      nn     = (n == 0) ? 1 : n;
      @(negedge clk);
      start = 1'b1; num_rows = 5'(n); num_passes = 8'(p); wr_valid = 1'b0; rd_ready = 1'b0;
      #1 chk("start_cycle_wr_ready", wr_ready, 0);
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         @(negedge clk);
         wr_valid = ($urandom_range(99) >= gap);
         rd_ready = ($urandom_range(99) >= gap);
         wr_data  = pat(writes);
         #1;
         chk("busy", busy, int'(wr_ready | rd_valid));
         if (wr_ready) chk("addr_wr", addr_wr, writes);
         if (we) writes++;
         if (rd_valid) begin
            chk("addr_rd", addr_rd, reads % nn);
            chk("rd_last", rd_last, int'((reads % nn) == nn - 1));
            chk("rd_final", rd_final, int'(reads == nn * p - 1));
            if (rd_ready) begin
               chk("rd_data", mem[addr_rd], pat(reads % nn));
               reads++;
            end
         end
         if (err) errs++;
         if (done) begin
            dones++;
            done_cyc = cyc;
            chk("busy_at_done", busy, 0);
            break;
         end
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
   endtask

   initial begin
      int w, r, d, e, c, hs, d0, e0;
      vecs[0] = '{4, 2, 0, 4, 8, 1, 0, 13};
      vecs[1] = '{16, 1, 0, 16, 16, 1, 0, 33};
      vecs[2] = '{1, 1, 0, 1, 1, 1, 0, 3};
      vecs[3] = '{1, 3, 0, 1, 3, 1, 0, 5};
      vecs[4] = '{3, 3, 40, 3, 9, 1, 0, -1};
      vecs[5] = '{0, 1, 0, 0, 0, 0, 1, -1};
      vecs[6] = '{17, 1, 0, 0, 0, 0, 1, -1};
      vecs[7] = '{2, 0, 0, 0, 0, 0, 1, -1};
      vecs[8] = '{2, 255, 0, 2, 510, 1, 0, 513};

      rst_n = 1'b0; start = 1'b0; num_rows = '0; num_passes = '0; abort = 1'b0;
      wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {wr_ready, we, addr_wr, rd_valid, addr_rd, rd_last, rd_final, busy, done, err}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("post_reset_outputs", {wr_ready, we, addr_wr, rd_valid, addr_rd, rd_last, rd_final, busy, done, err}, 0);

      for (int i = 0; i < 9; i++) begin
         run_tile(vecs[i].n, vecs[i].p, vecs[i].gap, w, r, d, e, c);
         chk($sformatf("v%0d_writes", i), w, vecs[i].exp_w);
         chk($sformatf("v%0d_reads", i), r, vecs[i].exp_r);
         chk($sformatf("v%0d_done", i), d, vecs[i].exp_done);
         chk($sformatf("v%0d_err", i), e, vecs[i].exp_err);
         if (vecs[i].exp_cyc >= 0) chk($sformatf("v%0d_done_cycle", i), c, vecs[i].exp_cyc);
      end

      // Abort at pass 1, row 2 of N=4 P=3, with an ignored start pulse during READ.
      @(negedge clk);
      start = 1'b1; num_rows = 5'd4; num_passes = 8'd3; wr_valid = 1'b1; rd_ready = 1'b1;
      d0 = done_events; e0 = err_events;
      @(posedge clk);
      #1 start = 1'b0; num_rows = '0; num_passes = '0;
      hs = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1 start = 1'b0;
         if (rd_valid && hs == 6) break;
         if (rd_valid) hs++;
         start = rd_valid && (hs == 3);
      end
      chk("abort_pos_addr", addr_rd, 2);
      chk("abort_pos_last", rd_last, 0);
      abort = 1'b1; start = 1'b1; num_rows = 5'd2; num_passes = 8'd1;
      @(posedge clk);
      #1 chk("abort_outputs", {wr_ready, we, addr_wr, rd_valid, addr_rd, rd_last, rd_final, busy, done, err}, 0);
      @(posedge clk);
      #1 chk("abort_beats_start", {busy, wr_ready}, 0);
      abort = 1'b0; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("abort_no_done", done_events, d0);
      chk("start_in_read_no_err", err_events, e0);
      run_tile(2, 1, 0, w, r, d, e, c);
      chk("after_abort_writes", w, 2);
      chk("after_abort_reads", r, 2);
      chk("after_abort_done_cycle", c, 5);

      // Async reset mid-LOAD, with an ignored start pulse during LOAD.
      @(negedge clk);
      start = 1'b1; num_rows = 5'd8; num_passes = 8'd1; wr_valid = 1'b1; rd_ready = 1'b1;
      e0 = err_events; d0 = done_events;
      @(posedge clk);
      #1 start = 1'b0; num_rows = '0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("load_addr_after_start", addr_wr, 2);
      chk("load_wr_ready", wr_ready, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {wr_ready, we, addr_wr, rd_valid, addr_rd, rd_last, rd_final, busy, done, err}, 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("idle_after_reset", {busy, wr_ready, we}, 0);
      chk("start_in_load_no_err", err_events, e0);
      chk("reset_no_done", done_events, d0);
      wr_valid = 1'b0; rd_ready = 1'b0;
      run_tile(3, 2, 0, w, r, d, e, c);
      chk("after_reset_reads", r, 6);
      chk("after_reset_done_cycle", c, 1 + 3 + 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
